// File: rtl/alu_pkg.sv
// Shared op, funct and FSM encodings for the ALU/MDU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND, OP_XOR, OP_SLL, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_DIVU,
      OP_REM, OP_REMU, OP_ADDI, OP_SRAI, OP_ILLEGAL
   } op_e;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   localparam logic [1:0] ALUOP_R  = 2'b10;
   localparam logic [1:0] ALUOP_I  = 2'b00;
   localparam logic [1:0] ALUOP_BR = 2'b01;

   localparam logic [9:0] F_AND  = 10'b0000000111;
   localparam logic [9:0] F_XOR  = 10'b0000000100;
   localparam logic [9:0] F_SLL  = 10'b0000000001;
   localparam logic [9:0] F_ADD  = 10'b0000000000;
   localparam logic [9:0] F_SUB  = 10'b0100000000;
   localparam logic [9:0] F_MUL  = 10'b0000001000;
   localparam logic [9:0] F_DIV  = 10'b0000001100;
   localparam logic [9:0] F_DIVU = 10'b0000001101;
   localparam logic [9:0] F_REM  = 10'b0000001110;
   localparam logic [9:0] F_REMU = 10'b0000001111;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_LS   = 3'b010;
   localparam logic [2:0] F3_SRAI = 3'b101;

   // I-type funct7 bits belong to the immediate, so only funct3 is decoded there.
   function automatic op_e decode(input logic [9:0] f, input logic [1:0] aop);
      op_e op;
      op = OP_ILLEGAL;
      case (aop)
         ALUOP_R: begin
            case (f)
               F_AND:  op = OP_AND;
               F_XOR:  op = OP_XOR;
               F_SLL:  op = OP_SLL;
               F_ADD:  op = OP_ADD;
               F_SUB:  op = OP_SUB;
               F_MUL:  op = OP_MUL;
               F_DIV:  op = OP_DIV;
               F_DIVU: op = OP_DIVU;
               F_REM:  op = OP_REM;
               F_REMU: op = OP_REMU;
               default: op = OP_ILLEGAL;
            endcase
         end
         ALUOP_I: begin
            case (f[2:0])
               F3_ADDI, F3_LS: op = OP_ADDI;
               F3_SRAI:        op = OP_SRAI;
               default:        op = OP_ILLEGAL;
            endcase
         end
         ALUOP_BR: op = OP_SUB;
         default:  op = OP_ILLEGAL;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on unsigned magnitudes.
module muldiv_iter #(
   parameter int XLEN    = 32,
   parameter int HAS_DIV = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start,
   input  logic            en,
   input  logic            div_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            last,
   output logic [XLEN-1:0] prod,
   output logic [XLEN-1:0] quo,
   output logic [XLEN-1:0] rem
);
   localparam int CW = $clog2(XLEN);

   // acc: partial product / partial remainder; q: multiplier / dividend->quotient; m: multiplicand / divisor
   logic [XLEN-1:0] acc, q, m;
   logic [CW-1:0]   cnt;
   logic            is_div;
   logic [XLEN:0]   r_sh, diff;

   assign last = (cnt == CW'(XLEN-1));

   // Next-step values are exposed so the final step can be captured on the same edge.
   always_comb begin
      r_sh = {acc, q[XLEN-1]};
      diff = r_sh - {1'b0, m};
      prod = acc + (q[0] ? m : '0);
      if (!diff[XLEN]) begin
         rem = diff[XLEN-1:0];
         quo = {q[XLEN-2:0], 1'b1};
      end else begin
         rem = r_sh[XLEN-1:0];
         quo = {q[XLEN-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc    <= '0;
         q      <= '0;
         m      <= '0;
         cnt    <= '0;
         is_div <= 1'b0;
      end else if (start) begin
         acc    <= '0;
         q      <= a;
         m      <= b;
         cnt    <= '0;
         is_div <= div_op && (HAS_DIV != 0);
      end else if (en) begin
         cnt <= cnt + CW'(1);
         if (is_div) begin
            acc <= rem;
            q   <= quo;
         end else begin
            acc <= prod;
            q   <= q >> 1;
            m   <= m << 1;
         end
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with built-in decode, single-cycle base ops and iterative mul/div/rem.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int HAS_DIV = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [9:0]      funct_i,
   input  logic [1:0]      ALUOp_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   output logic [XLEN-1:0] result_o,
   output logic            zero_o,
   output logic            busy_o
);
   localparam int SW = $clog2(XLEN);

   state_e          state;
   op_e             op, op_q;
   logic [XLEN-1:0] alu_res, a_mag, b_mag, fin, mag, prod, quo, rem;
   logic            accept, signed_div, is_dop, a_neg, b_neg, go_mul, go_div;
   logic            neg_q, neg_r, last;

   assign ready_o    = (state == S_IDLE) || (state == S_DONE);
   assign busy_o     = (state == S_MUL) || (state == S_DIV);
   assign op         = decode(funct_i, ALUOp_i);
   assign accept     = valid_i && ready_o && !flush_i;
   assign is_dop     = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   assign signed_div = (op == OP_DIV) || (op == OP_REM);
   assign a_neg      = signed_div && op_a_i[XLEN-1];
   assign b_neg      = signed_div && op_b_i[XLEN-1];
   assign a_mag      = a_neg ? -op_a_i : op_a_i;
   assign b_mag      = b_neg ? -op_b_i : op_b_i;
   assign go_mul     = (op == OP_MUL);
   // Divide by zero never iterates; its fixed result comes from the single-cycle path.
   assign go_div     = (HAS_DIV != 0) && is_dop && (op_b_i != '0);

   always_comb begin
      alu_res = '0;
      case (op)
         OP_AND:          alu_res = op_a_i & op_b_i;
         OP_XOR:          alu_res = op_a_i ^ op_b_i;
         OP_SLL:          alu_res = op_a_i << op_b_i[SW-1:0];
         OP_ADD, OP_ADDI: alu_res = op_a_i + op_b_i;
         OP_SUB:          alu_res = op_a_i - op_b_i;
         OP_SRAI:         alu_res = $signed(op_a_i) >>> op_b_i[SW-1:0];
         OP_DIV, OP_DIVU: alu_res = (HAS_DIV != 0) ? '1 : '0;
         OP_REM, OP_REMU: alu_res = (HAS_DIV != 0) ? op_a_i : '0;
         default:         alu_res = '0;
      endcase
   end

   always_comb begin
      mag = quo;
      fin = prod;
      if (op_q != OP_MUL) begin
         if ((op_q == OP_REM) || (op_q == OP_REMU)) begin
            mag = rem;
            fin = neg_r ? -mag : mag;
         end else begin
            fin = neg_q ? -mag : mag;
         end
      end
   end

   muldiv_iter #(.XLEN(XLEN), .HAS_DIV(HAS_DIV)) u_iter (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start  (accept && (go_mul || go_div)),
      .en     (busy_o),
      .div_op (go_div),
      .a      (a_mag),
      .b      (b_mag),
      .last   (last),
      .prod   (prod),
      .quo    (quo),
      .rem    (rem)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= S_IDLE;
         out_valid_o <= 1'b0;
         result_o    <= '0;
         zero_o      <= 1'b0;
         op_q        <= OP_ILLEGAL;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
      end else begin
         out_valid_o <= 1'b0;
         zero_o      <= 1'b0;
         if (flush_i) begin
            state <= S_IDLE;
         end else if (busy_o) begin
            if (last) begin
               state       <= S_DONE;
               out_valid_o <= 1'b1;
               result_o    <= fin;
               zero_o      <= (fin == '0);
            end
         end else begin
            state <= S_IDLE;
            if (valid_i) begin
               op_q  <= op;
               neg_q <= a_neg ^ b_neg;
               neg_r <= a_neg;
               if (go_mul) begin
                  state <= S_MUL;
               end else if (go_div) begin
                  state <= S_DIV;
               end else begin
                  out_valid_o <= 1'b1;
                  result_o    <= alu_res;
                  zero_o      <= (alu_res == '0);
               end
            end
         end
      end
   end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the pipeline's combinational ALU control/ALU pair.
- Decodes {funct7,funct3} and ALUOp itself, executes the base ops in one cycle, and adds iterative multiply/divide/remainder (RV-M subset).
- Handshake and flush let the EX stage stall on multi-cycle ops and abort them on a branch flush.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- HAS_DIV, 1, 0 removes the divide datapath; div/rem ops then return 0 with latency 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- valid_i  in  1  operation request
- ready_o  out  1  request accepted on a clock edge where valid_i && ready_o
- funct_i  in  10  {funct7, funct3}
- ALUOp_i  in  2  10 = R-type, 00 = I-type/load/store, 01 = branch compare
- op_a_i  in  XLEN  rs1 operand
- op_b_i  in  XLEN  rs2 or immediate operand
- flush_i  in  1  abort the current operation
- out_valid_o  out  1  one-cycle pulse; result_o valid while high
- result_o  out  XLEN  result
- zero_o  out  1  result_o == 0, qualified by out_valid_o
- busy_o  out  1  iterative operation in progress; drives the pipeline stall

Behaviour:
- Reset (rst_i low, async): state IDLE; ready_o=1; out_valid_o=0; result_o=0; zero_o=0; busy_o=0.
- Decode with ALUOp 10:
  - 0000000111 and; 0000000100 xor; 0000000001 sll; 0000000000 add; 0100000000 sub.
  - 0000001000 mul (low XLEN bits).
  - 0000001100 div; 0000001101 divu; 0000001110 rem; 0000001111 remu.
- Decode with ALUOp 00: funct3 000 addi; 010 load/store address add; 101 srai (arithmetic shift).
- Decode with ALUOp 01: sub (beq); zero_o gives the compare result.
- Any other combination: illegal; result 0, latency 1.
- Shift amount is op_b_i[log2(XLEN)-1:0]. All arithmetic wraps modulo 2^XLEN.
- States: IDLE, MUL, DIV, DONE. ready_o = (state==IDLE || state==DONE). busy_o = (state==MUL || state==DIV).
- Single-cycle op accepted at edge k: result registered at k; out_valid_o high for the cycle after k; state stays or returns to IDLE.
- mul accepted: -> MUL. Shift-add, 1 bit per cycle, XLEN cycles, then DONE. out_valid_o high in DONE. Latency XLEN+1.
- div/rem accepted: -> DIV.
  - Restoring division on magnitudes, XLEN cycles, then DONE; sign fix applied on the DONE load.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a). Latency XLEN+1.
- Divide by zero: no iteration, latency 1. Quotient = all ones; remainder = op_a_i.
- Signed overflow (-2^(XLEN-1) / -1): quotient = -2^(XLEN-1), remainder = 0. Falls out of the magnitude algorithm; no special case required.
- DONE lasts exactly one cycle. A new request accepted in DONE is legal (back-to-back); its state transition applies at that edge.
- flush_i is sampled at the edge and has priority over everything:
  - state -> IDLE, out_valid_o = 0 next cycle, the in-flight result is discarded.
  - A valid_i in the same cycle is not accepted (ready_o still reads 1 combinationally, but the request is dropped).
  - The requester must re-present the op after the flush.
- Operands and decoded op are latched at accept. Inputs may change freely while busy_o=1.
- out_valid_o never pulses twice for one request and never pulses for a flushed request.
- Reset asserted mid-operation behaves as flush plus clearing all outputs.

Decomposition:
- Package alu_pkg holds:
  - 4-bit op enum: AND, XOR, SLL, ADD, SUB, MUL, DIV, DIVU, REM, REMU, ADDI, SRAI, ILLEGAL.
  - funct_i constants and ALUOp constants (ALUOP_R, ALUOP_I, ALUOP_BR).
  - FSM state encoding.
- Sub-module muldiv_iter: iterative shift-add/restoring datapath with start/done. The top holds decode, single-cycle ALU, FSM and handshake.

Test Plan:
- ALUOp 10, funct 0100000000, a=5, b=5 -> out_valid_o next cycle, result 0, zero_o=1. Same op, a=3, b=5 -> 0xFFFFFFFE, zero_o=0.
- ALUOp 00, funct3 101, a=0x80000000, b=4 -> 0xF8000000, latency 1. funct3 010, a=0x100, b=0xFFFFFFFC -> 0xFC.
- mul a=0xFFFFFFFF (-1), b=7 -> busy_o=1 for 32 cycles, result 0xFFFFFFF9 exactly 33 cycles after accept. ready_o=0 throughout MUL; a valid_i held high is not accepted until DONE.
- div a=-7, b=2 -> quotient -3 (0xFFFFFFFD). rem same operands -> -1. divu a=7, b=0 -> 0xFFFFFFFF at latency 1. rem a=0x80000000, b=-1 -> 0.
- Start divu, assert flush_i on cycle 10 -> IDLE next cycle, no out_valid_o ever. A following add 2+3 -> 5 at latency 1.
- Back-to-back: new xor accepted during mul DONE -> two consecutive out_valid_o pulses with the correct results. Reset pulse mid-DIV -> all outputs 0 immediately (async).
